// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned PC_W = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0] HALT_OPCODE = 5'b00000;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StHold,
        StHalted
    } fetch_state_e;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read port: single request/response handshake.
interface fetch_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_done;
    logic [15:0]     imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_done, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_done, output imem_rdata);

endinterface

// File: rtl/fetch_skid.sv
// One-entry holding buffer for an instruction that returned while decode was stalled.
module fetch_skid
    import fetch_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [15:0]     instr_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            valid_o,
    output logic [15:0]     instr_o,
    output logic [PC_W-1:0] pc_o
);

    logic            valid_q;
    logic [15:0]     instr_q;
    logic [PC_W-1:0] pc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, stall skid, redirect and HALT handling.
// Optional FETCH_ALIGN_CHECK_EN: an odd redirect target halts instead of being realigned.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_in,
    input  logic            redirect_in,
    input  logic [PC_W-1:0] redirect_pc_in,
    fetch_if.master         imem,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] pc_plus2_out,
    output logic [15:0]     instr_out,
    output logic            halt_out,
    output logic            bubble_out
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            drop_q, drop_d;
    logic [15:0]     last_instr_q, last_instr_d;
    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic            last_bubble_q, last_bubble_d;

    logic            req, present, skid_load, skid_clear;
    logic [15:0]     pres_instr;
    logic [PC_W-1:0] pres_pc;
    logic            skid_valid;
    logic [15:0]     skid_instr;
    logic [PC_W-1:0] skid_pc;
    logic [PC_W-1:0] target;
    logic            misalign;
    logic            in_flight;

`ifdef FETCH_ALIGN_CHECK_EN
    assign target   = redirect_pc_in;
    assign misalign = redirect_pc_in[0];
`else
    assign target   = redirect_pc_in & ~PC_W'(1);
    assign misalign = 1'b0;
`endif

    // A request is still owed a response after this cycle; its data must be dropped.
    assign in_flight = ((state_q == StWait) || drop_q) && !imem.imem_done;

    fetch_skid u_skid (
        .clk_i   (clk),
        .rst_ni  (rst),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .instr_i (imem.imem_rdata),
        .pc_i    (pc_q),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        drop_d        = drop_q;
        last_instr_d  = last_instr_q;
        last_pc_d     = last_pc_q;
        last_bubble_d = last_bubble_q;
        req           = 1'b0;
        present       = 1'b0;
        skid_load     = 1'b0;
        skid_clear    = 1'b0;
        pres_instr    = NOP_INSTR;
        pres_pc       = pc_q;

        case (state_q)
            StFetch: begin
                req     = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (imem.imem_done) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = StFetch;
                    end else if (stall_in) begin
                        skid_load = 1'b1;
                        state_d   = StHold;
                    end else begin
                        present    = 1'b1;
                        pres_instr = imem.imem_rdata;
                    end
                end
            end
            StHold: begin
                if (!stall_in && skid_valid) begin
                    present    = 1'b1;
                    pres_instr = skid_instr;
                    pres_pc    = skid_pc;
                    skid_clear = 1'b1;
                end
            end
            StHalted: begin
                if (imem.imem_done) drop_d = 1'b0;
            end
            default: state_d = StFetch;
        endcase

        if (present) begin
            pc_d          = pres_pc + PC_W'(2);
            last_instr_d  = pres_instr;
            last_pc_d     = pres_pc;
            last_bubble_d = 1'b0;
            state_d       = is_halt(pres_instr) ? StHalted : StFetch;
        end

        // Redirect beats stall and memory response; nothing is presented this cycle.
        if (redirect_in) begin
            req           = 1'b0;
            present       = 1'b0;
            skid_load     = 1'b0;
            skid_clear    = 1'b1;
            pc_d          = target;
            drop_d        = in_flight;
            last_instr_d  = last_instr_q;
            last_pc_d     = last_pc_q;
            last_bubble_d = last_bubble_q;
            if (misalign) begin
                state_d       = StHalted;
                last_instr_d  = NOP_INSTR;
                last_pc_d     = target;
                last_bubble_d = 1'b1;
            end else begin
                state_d = in_flight ? StWait : StFetch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            last_instr_q  <= NOP_INSTR;
            last_pc_q     <= RESET_PC;
            last_bubble_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            last_instr_q  <= last_instr_d;
            last_pc_q     <= last_pc_d;
            last_bubble_q <= last_bubble_d;
        end
    end

    always_comb begin
        instr_out  = NOP_INSTR;
        pc_out     = pc_q;
        halt_out   = 1'b0;
        bubble_out = 1'b1;
        if (present) begin
            instr_out  = pres_instr;
            pc_out     = pres_pc;
            halt_out   = is_halt(pres_instr);
            bubble_out = 1'b0;
        end else if (state_q == StHalted) begin
            instr_out  = last_instr_q;
            pc_out     = last_pc_q;
            halt_out   = 1'b1;
            bubble_out = last_bubble_q;
        end
    end

    assign pc_plus2_out   = pc_out + PC_W'(2);
    assign imem.imem_req  = req && rst;
    assign imem.imem_addr = pc_q;

endmodule
